// File: rtl/vec_cache_bank_rd_arb.sv
// vec_cache_bank_rd_arb
// Per-bank read-request arbiter for one output port of the N-to-4 read
// crossbar. Requests whose bank select matches BANK_ID are arbitrated
// round-robin. The winner's payload is captured into a single registered
// output slot. A credit counter that mirrors the free entries of the bank's
// downstream request queue gates every issue.
//
// Ports:
//   clk, rst    clock; synchronous active-high reset
//   in_vld      per-requester request valid
//   in_select   per-requester target bank
//   in_pld      per-requester request payload
//   in_rdy      one-hot accept toward the winning requester (combinational)
//   out_vld     registered request valid toward the bank
//   out_pld     registered request payload
//   out_rdy     bank accepts out_pld
//   credit_rtn  one-cycle pulse: the bank freed one queue entry
//   credit_cnt  credits currently available
//   grant_id    index of the last granted requester
//   credit_err  sticky: a credit was returned while the counter was full
module vec_cache_bank_rd_arb #(
  parameter int unsigned N          = 8,
  parameter int unsigned PLD_WIDTH  = 128,
  parameter logic [1:0]  BANK_ID    = 2'd0,
  parameter int unsigned CREDIT_NUM = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N-1:0]                      in_vld,
  input  logic [N-1:0][1:0]                 in_select,
  input  logic [N-1:0][PLD_WIDTH-1:0]       in_pld,
  output logic [N-1:0]                      in_rdy,
  output logic                              out_vld,
  output logic [PLD_WIDTH-1:0]              out_pld,
  input  logic                              out_rdy,
  input  logic                              credit_rtn,
  output logic [$clog2(CREDIT_NUM+1)-1:0]   credit_cnt,
  output logic [$clog2(N)-1:0]              grant_id,
  output logic                              credit_err
);

  localparam int unsigned CW = $clog2(CREDIT_NUM + 1);
  localparam int unsigned IW = $clog2(N);

  logic [N-1:0]           req;
  logic [IW-1:0]          winner;
  logic                   slot_free;
  logic                   can_issue;
  int unsigned            idx;

  logic                   out_vld_q,    out_vld_d;
  logic [PLD_WIDTH-1:0]   out_pld_q,    out_pld_d;
  logic [IW-1:0]          grant_id_q,   grant_id_d;
  logic [IW-1:0]          rr_ptr_q,     rr_ptr_d;
  logic [CW-1:0]          credit_cnt_q, credit_cnt_d;
  logic                   credit_err_q, credit_err_d;

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      req[i] = in_vld[i] & (in_select[i] == BANK_ID);
    end
  end

  // Scan from rr_ptr upward with wrap-around; the first requester hit wins.
  always_comb begin
    winner = '0;
    idx    = 0;
    for (int unsigned off = N; off > 0; off--) begin
      // Walk the scan order backwards so the last hit is the first in order.
      idx = (32'(rr_ptr_q) + off - 1) % N;
      if (req[idx]) begin
        winner = IW'(idx);
      end
    end
  end

  assign slot_free = !out_vld_q | out_rdy;
  // Registered count only: a credit returned at zero enables issue next cycle.
  assign can_issue = !rst & slot_free & (credit_cnt_q != '0) & (|req);

  always_comb begin
    in_rdy = '0;
    if (can_issue) begin
      in_rdy[winner] = 1'b1;
    end
  end

  always_comb begin
    out_vld_d    = out_vld_q;
    out_pld_d    = out_pld_q;
    grant_id_d   = grant_id_q;
    rr_ptr_d     = rr_ptr_q;
    credit_cnt_d = credit_cnt_q;
    credit_err_d = credit_err_q;

    if (can_issue) begin
      out_vld_d  = 1'b1;
      out_pld_d  = in_pld[winner];
      grant_id_d = winner;
      rr_ptr_d   = (winner == IW'(N - 1)) ? '0 : winner + 1'b1;
    end else if (out_vld_q && out_rdy) begin
      out_vld_d = 1'b0;
    end

    // Grant and return in the same cycle cancel out.
    if (can_issue && !credit_rtn) begin
      credit_cnt_d = credit_cnt_q - 1'b1;
    end else if (!can_issue && credit_rtn) begin
      if (credit_cnt_q == CW'(CREDIT_NUM)) begin
        credit_err_d = 1'b1;
      end else begin
        credit_cnt_d = credit_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q    <= 1'b0;
      out_pld_q    <= '0;
      grant_id_q   <= '0;
      rr_ptr_q     <= '0;
      credit_cnt_q <= CW'(CREDIT_NUM);
      credit_err_q <= 1'b0;
    end else begin
      out_vld_q    <= out_vld_d;
      out_pld_q    <= out_pld_d;
      grant_id_q   <= grant_id_d;
      rr_ptr_q     <= rr_ptr_d;
      credit_cnt_q <= credit_cnt_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign out_vld    = out_vld_q;
  assign out_pld    = out_pld_q;
  assign grant_id   = grant_id_q;
  assign credit_cnt = credit_cnt_q;
  assign credit_err = credit_err_q;

endmodule
